fifo_ptr_ctrl: RTL and testbench

Single-clock FIFO pointer and flag controller. It owns the write and read pointers of a 2^ADDR_W-entry FIFO and drives the memory write/read enables and addresses. It generates full/empty/almost flags, an occupancy count and sticky overflow/underflow errors. It also exports Gray-coded copies of both pointers, registered and glitch-free, so a later dual-clock variant can synchronise them unchanged.

---
 rtl/fifo_pkg.sv | 15 +
 rtl/binary_to_gray.sv | 12 +
 rtl/fifo_ptr_ctrl.sv | 133 +++++++++++++
 tb/tb_fifo_ptr_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO pointer controller family.
package fifo_pkg;

  // Default address width; the FIFO depth is 2**ADDR_W entries.
  localparam int ADDR_W_DEF = 4;

  // Pointers carry one extra wrap bit beyond the address.
  localparam int PTR_W_DEF = ADDR_W_DEF + 1;

  // Reflected binary Gray code of a default-width pointer.
  function automatic logic [PTR_W_DEF-1:0] bin2gray(input logic [PTR_W_DEF-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/binary_to_gray.sv
// Combinational binary-to-Gray converter for an N-bit pointer.
module binary_to_gray #(
  parameter int N = 5
) (
  input  logic [N-1:0] bin_i,
  output logic [N-1:0] gray_o
);

  // Adjacent binary values map to codes differing in exactly one bit.
  assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// Single-clock FIFO pointer/flag controller. Owns the write and read
// pointers, drives the storage strobes and addresses, and exports
// registered Gray copies of both pointers for later clock-domain crossing.
module fifo_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int AF_LVL = (1 << ADDR_W) - 1,
  parameter int AE_LVL = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req,
  input  logic              rd_req,
  input  logic              clr_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic [ADDR_W:0]   wptr_gray,
  output logic [ADDR_W:0]   rptr_gray,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              ovf,
  output logic              udf
);

  localparam int PW = ADDR_W + 1;

  // Thresholds resized once to the count width so the compares stay unsigned.
  localparam logic [ADDR_W:0] AF_TH = PW'(AF_LVL);
  localparam logic [ADDR_W:0] AE_TH = PW'(AE_LVL);

  logic [ADDR_W:0] wptr_q, wptr_d;
  logic [ADDR_W:0] rptr_q, rptr_d;
  logic [ADDR_W:0] wgray_q, wgray_d;
  logic [ADDR_W:0] rgray_q, rgray_d;
  logic            ovf_q, ovf_d;
  logic            udf_q, udf_d;

  logic            full_w;
  logic            empty_w;
  logic [ADDR_W:0] count_w;
  logic            wr_acc;
  logic            rd_acc;

  // Status derived purely from the registered pointers. The extra MSB
  // separates "same address, same lap" (empty) from "same address, one lap
  // ahead" (full), so the two never alias at any pointer value.
  always_comb begin
    empty_w = (wptr_q == rptr_q);
    full_w  = (wptr_q[ADDR_W] != rptr_q[ADDR_W]) &&
              (wptr_q[ADDR_W-1:0] == rptr_q[ADDR_W-1:0]);
    count_w = wptr_q - rptr_q;
  end

  // Acceptance, next pointers and sticky error next-state. Write and read
  // are judged independently against the current flags, so at full a
  // simultaneous read still drains while the write is refused.
  always_comb begin
    wr_acc = wr_req & ~full_w;
    rd_acc = rd_req & ~empty_w;

    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (wr_acc) wptr_d = wptr_q + PW'(1);
    if (rd_acc) rptr_d = rptr_q + PW'(1);

    // A new error event outranks a clear arriving in the same cycle.
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (clr_err) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (wr_req & full_w)  ovf_d = 1'b1;
    if (rd_req & empty_w) udf_d = 1'b1;
  end

  // Gray conversion sits ahead of the Gray registers, so the exported codes
  // come straight from flops and cannot glitch.
  binary_to_gray #(.N(PW)) u_wptr_gray (
    .bin_i  (wptr_d),
    .gray_o (wgray_d)
  );

  binary_to_gray #(.N(PW)) u_rptr_gray (
    .bin_i  (rptr_d),
    .gray_o (rgray_d)
  );

  // Pointer, Gray and error state; reset empties the FIFO immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      wgray_q <= '0;
      rgray_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      wgray_q <= wgray_d;
      rgray_q <= rgray_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Storage strobes and addresses are combinational in the request cycle;
  // storage captures on the same edge that advances the pointer.
  assign mem_we    = wr_acc;
  assign mem_re    = rd_acc;
  assign mem_waddr = wptr_q[ADDR_W-1:0];
  assign mem_raddr = rptr_q[ADDR_W-1:0];

  assign wptr_gray = wgray_q;
  assign rptr_gray = rgray_q;

  assign full         = full_w;
  assign empty        = empty_w;
  assign count        = count_w;
  assign almost_full  = (count_w >= AF_TH);
  assign almost_empty = (count_w <= AE_TH);

  assign ovf = ovf_q;
  assign udf = udf_q;

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Scoreboard bench for fifo_ptr_ctrl with ADDR_W=2, AF_LVL=3, AE_LVL=1.
module tb_fifo_ptr_ctrl;

  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_req = 1'b0;
  logic          rd_req = 1'b0;
  logic          clr_err = 1'b0;
  logic          mem_we, mem_re;
  logic [AW-1:0] mem_waddr, mem_raddr;
  logic [AW:0]   wptr_gray, rptr_gray, count;
  logic          full, empty, almost_full, almost_empty, ovf, udf;

  fifo_ptr_ctrl #(.ADDR_W(AW), .AF_LVL(3), .AE_LVL(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_req       (wr_req),
    .rd_req       (rd_req),
    .clr_err      (clr_err),
    .mem_we       (mem_we),
    .mem_waddr    (mem_waddr),
    .mem_re       (mem_re),
    .mem_raddr    (mem_raddr),
    .wptr_gray    (wptr_gray),
    .rptr_gray    (rptr_gray),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .ovf          (ovf),
    .udf          (udf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [AW-1:0] waddr;
    logic          re;
    logic [AW-1:0] raddr;
    logic [AW:0]   wg;
    logic [AW:0]   rg;
    logic          full;
    logic          empty;
    logic          af;
    logic          ae;
    logic [AW:0]   cnt;
    logic          ovf;
    logic          udf;
    bit            strobes;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: occupancy and lifetime transfer totals.
  int occ  = 0;
  int wtot = 0;
  int rtot = 0;
  bit m_ovf = 1'b0;
  bit m_udf = 1'b0;

  function automatic logic [AW:0] gray_of(input int n);
    logic [AW:0] b;
    b = (AW+1)'(n % (2 * DEPTH));
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] ex);
    checks++;
    if (act !== ex) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, ex, $time);
    end
  endtask

  // One clock of stimulus: drive, predict this cycle's outputs, advance model.
  task automatic cycle(input bit w, input bit r, input bit c, input bit rs);
    exp_t e;
    bit   wacc, racc;
    @(posedge clk);
    #1;
    wr_req  = w;
    rd_req  = r;
    clr_err = c;
    rst     = rs;
    if (rs) begin
      occ = 0; wtot = 0; rtot = 0; m_ovf = 1'b0; m_udf = 1'b0;
    end
    wacc      = w && (occ < DEPTH);
    racc      = r && (occ > 0);
    e.we      = wacc;
    e.re      = racc;
    e.waddr   = AW'(wtot % DEPTH);
    e.raddr   = AW'(rtot % DEPTH);
    e.wg      = gray_of(wtot);
    e.rg      = gray_of(rtot);
    e.full    = (occ == DEPTH);
    e.empty   = (occ == 0);
    e.af      = (occ >= 3);
    e.ae      = (occ <= 1);
    e.cnt     = (AW+1)'(occ);
    e.ovf     = m_ovf;
    e.udf     = m_udf;
    e.strobes = !rs;
    exp_q.push_back(e);
    if (!rs) begin
      m_ovf = (w && occ == DEPTH) || (m_ovf && !c);
      m_udf = (r && occ == 0)     || (m_udf && !c);
      occ   = occ + int'(wacc) - int'(racc);
      wtot  = wtot + int'(wacc);
      rtot  = rtot + int'(racc);
    end
  endtask

  exp_t        mon_e;
  logic [AW:0] prev_wg = '0;
  logic [AW:0] prev_rg = '0;

  // Monitor: compare every presented cycle against the oldest prediction.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      if (mon_e.strobes) begin
        chk("mem_we",    8'(mem_we),    8'(mon_e.we));
        chk("mem_re",    8'(mem_re),    8'(mon_e.re));
        chk("wg_step",   8'($countones(prev_wg ^ wptr_gray) <= 1), 8'(1));
        chk("rg_step",   8'($countones(prev_rg ^ rptr_gray) <= 1), 8'(1));
      end
      chk("mem_waddr",    8'(mem_waddr),    8'(mon_e.waddr));
      chk("mem_raddr",    8'(mem_raddr),    8'(mon_e.raddr));
      chk("wptr_gray",    8'(wptr_gray),    8'(mon_e.wg));
      chk("rptr_gray",    8'(rptr_gray),    8'(mon_e.rg));
      chk("full",         8'(full),         8'(mon_e.full));
      chk("empty",        8'(empty),        8'(mon_e.empty));
      chk("almost_full",  8'(almost_full),  8'(mon_e.af));
      chk("almost_empty", 8'(almost_empty), 8'(mon_e.ae));
      chk("count",        8'(count),        8'(mon_e.cnt));
      chk("ovf",          8'(ovf),          8'(mon_e.ovf));
      chk("udf",          8'(udf),          8'(mon_e.udf));
      prev_wg = wptr_gray;
      prev_rg = rptr_gray;
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset, including requests that must be ignored while held.
    cycle(0, 0, 0, 1);
    cycle(1, 1, 1, 1);
    cycle(0, 0, 0, 0);
    // Fill to full, then overflow and clear.
    repeat (4) cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 0);
    // Simultaneous at full, then at count 2.
    cycle(1, 1, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(1, 1, 0, 0);
    cycle(0, 0, 1, 0);
    // Drain and underflow; set beats clear in the same cycle.
    repeat (3) cycle(0, 1, 0, 0);
    cycle(0, 1, 1, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 0);
    // Wrap at mid-occupancy.
    repeat (2) cycle(1, 0, 0, 0);
    repeat (20) cycle(1, 1, 0, 0);
    // Reset mid-operation discards contents.
    cycle(1, 0, 0, 1);
    cycle(0, 0, 0, 0);
    // Randomised traffic with occasional clears and resets.
    repeat (2000) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 99) == 0));
    end
    cycle(0, 0, 0, 0);
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d expected=0 pending predictions", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
